// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream RGB test-pattern source (colour bars, gray ramp, 8x8 checkerboard, solid)
// with tuser on the first pixel of a frame, tlast on the last pixel of a line.
module axis_video_pattern_gen #(
  parameter int IMAGE_WIDTH  = 1920,
  parameter int IMAGE_HEIGHT = 1080,
  parameter int LINE_GAP     = 0,
  parameter int FRAME_GAP    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_count
);
  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam logic [XW-1:0] X_LAST   = XW'(IMAGE_WIDTH - 1);
  localparam logic [XW-1:0] X_ONE    = XW'(1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMAGE_HEIGHT - 1);
  localparam logic [YW-1:0] Y_ONE    = YW'(1);
  localparam logic [XW-1:0] BAR_LAST = XW'(IMAGE_WIDTH / 8 - 1);
  localparam logic [15:0]   LGAP_INIT = 16'(LINE_GAP - 1);
  localparam logic [15:0]   FGAP_INIT = 16'(FRAME_GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_LGAP, ST_FGAP} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d, bar_cnt_q, bar_cnt_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [15:0]   gap_cnt_q, gap_cnt_d, frame_count_q, frame_count_d;
  logic [1:0]    pat_q, pat_d;
  logic [23:0]   solid_q, solid_d, tdata_q, tdata_d, pix_s;
  logic          tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic          frame_done_q, frame_done_d, busy_q, busy_d;
  logic          xfer_s, load_s, start_s, y3_s;
  logic [7:0]    x8_s;

  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    logic [23:0] c;
    case (bar)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  function automatic logic [23:0] pixel(input logic [1:0] pat, input logic [23:0] solid,
                                        input logic [7:0] xl, input logic y3, input logic [2:0] bar);
    logic [23:0] p;
    case (pat)
      2'd0:    p = bar_colour(bar);
      2'd1:    p = {xl, xl, xl};
      2'd2:    p = (xl[3] ^ y3) ? 24'hFFFFFF : 24'h000000;
      default: p = solid;
    endcase
    return p;
  endfunction

  // Pattern inputs are the low coordinate bits, zero-padded for narrow counters
  if (XW >= 8) begin : g_xwide
    assign x8_s = x_d[7:0];
  end else begin : g_xnarrow
    assign x8_s = {{(8 - XW){1'b0}}, x_d};
  end
  if (YW >= 4) begin : g_ywide
    assign y3_s = y_d[3];
  end else begin : g_ynarrow
    assign y3_s = 1'b0;
  end

  // Next-state: FSM, raster counters, bar counter and beat control
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    bar_idx_d     = bar_idx_q;
    bar_cnt_d     = bar_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    pat_d         = pat_q;
    solid_d       = solid_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    load_s        = 1'b0;
    start_s       = 1'b0;
    xfer_s        = tvalid_q & m_axis_tready;
    case (state_q)
      ST_IDLE: begin
        start_s = enable;
      end
      ST_ACTIVE: begin
        if (xfer_s && !tlast_q) begin
          x_d    = x_q + X_ONE;
          load_s = 1'b1;
          if (bar_idx_q == 3'd7) begin
            bar_cnt_d = bar_cnt_q;
          end else if (bar_cnt_q == BAR_LAST) begin
            bar_idx_d = bar_idx_q + 3'd1;
            bar_cnt_d = '0;
          end else begin
            bar_cnt_d = bar_cnt_q + X_ONE;
          end
        end else if (xfer_s) begin
          x_d       = '0;
          bar_idx_d = 3'd0;
          bar_cnt_d = '0;
          if (y_q != Y_LAST) begin
            y_d = y_q + Y_ONE;
            if (LINE_GAP > 0) begin
              state_d   = ST_LGAP;
              gap_cnt_d = LGAP_INIT;
            end else begin
              load_s = 1'b1;
            end
          end else begin
            y_d           = '0;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            if (FRAME_GAP > 0) begin
              state_d   = ST_FGAP;
              gap_cnt_d = FGAP_INIT;
            end else if (enable) begin
              start_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_LGAP: begin
        if (gap_cnt_q == 16'd0) begin
          state_d = ST_ACTIVE;
          load_s  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      ST_FGAP: begin
        if (gap_cnt_q != 16'd0) begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end else if (enable) begin
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A new frame re-latches the pattern selection and restarts the raster
    if (start_s) begin
      state_d   = ST_ACTIVE;
      pat_d     = pattern_sel;
      solid_d   = solid_rgb;
      x_d       = '0;
      y_d       = '0;
      bar_idx_d = 3'd0;
      bar_cnt_d = '0;
      load_s    = 1'b1;
    end else begin
      pat_d = pat_d;
    end
    if (load_s) begin
      tvalid_d = 1'b1;
      tuser_d  = (x_d == '0) && (y_d == '0);
      tlast_d  = (x_d == X_LAST);
    end else if (xfer_s) begin
      tvalid_d = 1'b0;
      tuser_d  = 1'b0;
      tlast_d  = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Pixel value for the beat being loaded; otherwise the presented beat holds
  always_comb begin
    pix_s = pixel(pat_d, solid_d, x8_s, y3_s, bar_idx_d);
    if (load_s) begin
      tdata_d = pix_s;
    end else begin
      tdata_d = tdata_q;
    end
  end

  // State, counters and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      bar_idx_q     <= 3'd0;
      bar_cnt_q     <= '0;
      gap_cnt_q     <= 16'd0;
      pat_q         <= 2'd0;
      solid_q       <= 24'd0;
      tdata_q       <= 24'd0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      bar_idx_q     <= bar_idx_d;
      bar_cnt_q     <= bar_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      pat_q         <= pat_d;
      solid_q       <= solid_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_done    = frame_done_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed bench for axis_video_pattern_gen on a 16x4 frame: one instance without gaps,
// one with LINE_GAP=3 / FRAME_GAP=5.
module tb_axis_video_pattern_gen;
  localparam int W = 16;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, enable_g = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'd0;
  logic        tready = 1'b0, tready_g = 1'b0;
  logic [23:0] tdata, tdata_g;
  logic        tvalid, tlast, tuser, fdone, busy;
  logic        tvalid_g, tlast_g, tuser_g, fdone_g, busy_g;
  logic [15:0] fcount, fcount_g;

  int errors = 0;
  int checks = 0;

  logic [23:0] cap_data [0:255];
  logic        cap_last [0:255];
  logic        cap_user [0:255];
  int          cap_gap  [0:255];
  int          hold_viol, drop_viol, fd_seen, stall_cycles;

  always #5 clk = ~clk;

  axis_video_pattern_gen #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .LINE_GAP(0), .FRAME_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .m_axis_tready(tready), .frame_done(fdone), .busy(busy), .frame_count(fcount));

  axis_video_pattern_gen #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .LINE_GAP(3), .FRAME_GAP(5)) dut_g (
    .clk(clk), .rst_n(rst_n), .enable(enable_g), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .m_axis_tdata(tdata_g), .m_axis_tvalid(tvalid_g), .m_axis_tlast(tlast_g), .m_axis_tuser(tuser_g),
    .m_axis_tready(tready_g), .frame_done(fdone_g), .busy(busy_g), .frame_count(fcount_g));

  // Hand-written bar table for W=16: BAR_W=2, so bar = x/2
  function automatic logic [23:0] exp_bar(input int x);
    case (x / 2)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; enable_g = 1'b0; tready = 1'b0; tready_g = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; records n transferred beats starting at index base
  task automatic capture(input int base, input int n, input bit rnd, input bit g, output int got);
    logic v, r, stalled, l, u, pl, pu;
    logic [23:0] d, pd;
    int idle, cyc;
    got = 0; idle = 0; cyc = 0; stalled = 1'b0; pd = 24'd0; pl = 1'b0; pu = 1'b0;
    hold_viol = 0; drop_viol = 0; fd_seen = 0; stall_cycles = 0;
    while (got < n && cyc < 4000) begin
      v = g ? tvalid_g : tvalid;
      d = g ? tdata_g : tdata;
      l = g ? tlast_g : tlast;
      u = g ? tuser_g : tuser;
      if (g ? fdone_g : fdone) fd_seen++;
      if (stalled && !v) drop_viol++;
      else if (stalled && (d !== pd || l !== pl || u !== pu)) hold_viol++;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (g) tready_g = r; else tready = r;
      if (v && r) begin
        cap_data[base+got] = d; cap_last[base+got] = l; cap_user[base+got] = u;
        cap_gap[base+got] = idle; idle = 0; got++;
      end else if (!v) begin
        idle++;
      end
      if (v && !r) stall_cycles++;
      stalled = v && !r; pd = d; pl = l; pu = u;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({tvalid, tlast, tuser, fdone, busy, fcount, tdata} !== 45'd0) begin
      errors++; $display("FAIL reset_outputs: got v%b l%b u%b fd%b b%b fc%h d%h, want all zero",
                         tvalid, tlast, tuser, fdone, busy, fcount, tdata);
    end
    do_reset();
    repeat (3) @(posedge clk); #1;
    checks++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_no_enable: got tvalid=%b busy=%b, want 0 0", tvalid, busy);
    end
  endtask

  task automatic test_colour_bars();
    int got;
    do_reset();
    pattern_sel = 2'd0; enable = 1'b1;
    capture(0, 64, 1'b0, 1'b0, got);
    checks++;
    if (got !== 64) begin errors++; $display("FAIL bars_count: got %0d beats, want 64", got); end
    checks++;
    if (cap_gap[0] !== 1) begin errors++; $display("FAIL start_latency: got %0d idle cycles, want 1", cap_gap[0]); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if ({cap_data[i], cap_user[i], cap_last[i]} !== {exp_bar(i % 16), (i == 0), (i % 16 == 15)}) begin
        errors++; $display("FAIL bars_beat%0d: got %h u%b l%b, want %h u%b l%b", i, cap_data[i],
                           cap_user[i], cap_last[i], exp_bar(i % 16), (i == 0), (i % 16 == 15));
      end
      if (i > 0) begin
        checks++;
        if (cap_gap[i] !== 0) begin errors++; $display("FAIL bars_gap%0d: got %0d, want 0", i, cap_gap[i]); end
      end
    end
    checks++;
    if ({fdone, fcount} !== {1'b1, 16'd1}) begin
      errors++; $display("FAIL bars_frame_end: got fd=%b fc=%0d, want 1 1", fdone, fcount);
    end
    checks++;
    if ({tvalid, tuser, tlast, tdata} !== {3'b110, 24'hFFFFFF}) begin
      errors++; $display("FAIL bars_next_frame: got v%b u%b l%b %h, want v1 u1 l0 ffffff",
                         tvalid, tuser, tlast, tdata);
    end
    tready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({fdone, tvalid, tuser} !== 3'b011) begin
      errors++; $display("FAIL bars_done_pulse: got fd=%b v=%b u=%b, want 0 1 1", fdone, tvalid, tuser);
    end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    int got;
    do_reset();
    pattern_sel = 2'd0; enable = 1'b1;
    capture(0, 64, 1'b1, 1'b0, got);
    checks++;
    if (got !== 64) begin errors++; $display("FAIL bp_count: got %0d beats, want 64", got); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if ({cap_data[i], cap_user[i], cap_last[i]} !== {exp_bar(i % 16), (i == 0), (i % 16 == 15)}) begin
        errors++; $display("FAIL bp_beat%0d: got %h u%b l%b, want %h u%b l%b", i, cap_data[i],
                           cap_user[i], cap_last[i], exp_bar(i % 16), (i == 0), (i % 16 == 15));
      end
    end
    checks++;
    if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls, want 0", hold_viol); end
    checks++;
    if (drop_viol !== 0) begin errors++; $display("FAIL bp_drop: got %0d valid drops, want 0", drop_viol); end
    checks++;
    if ({fdone, fcount} !== {1'b1, 16'd1}) begin
      errors++; $display("FAIL bp_frame_end: got fd=%b fc=%0d, want 1 1", fdone, fcount);
    end
    enable = 1'b0;
  endtask

  task automatic test_gaps();
    int got, want;
    do_reset();
    pattern_sel = 2'd0; enable_g = 1'b1;
    capture(0, 65, 1'b0, 1'b1, got);
    checks++;
    if (got !== 65) begin errors++; $display("FAIL gap_count: got %0d beats, want 65", got); end
    for (int i = 1; i < 65; i++) begin
      want = (i == 64) ? 5 : ((i % 16 == 0) ? 3 : 0);
      checks++;
      if (cap_gap[i] !== want) begin errors++; $display("FAIL gap_before%0d: got %0d, want %0d", i, cap_gap[i], want); end
    end
    checks++;
    if ({cap_user[64], cap_data[64]} !== {1'b1, 24'hFFFFFF}) begin
      errors++; $display("FAIL gap_next_frame: got u%b %h, want u1 ffffff", cap_user[64], cap_data[64]);
    end
    checks++;
    if ({cap_last[15], cap_data[16], cap_user[16]} !== {1'b1, 24'hFFFFFF, 1'b0}) begin
      errors++; $display("FAIL gap_line_wrap: got l%b %h u%b, want l1 ffffff u0", cap_last[15], cap_data[16], cap_user[16]);
    end
    checks++;
    if (fd_seen !== 1 || fcount_g !== 16'd1) begin
      errors++; $display("FAIL gap_frame_done: got pulses=%0d fc=%0d, want 1 1", fd_seen, fcount_g);
    end
    enable_g = 1'b0;
  endtask

  task automatic test_enable_drop();
    int got1, got2, vcnt;
    do_reset();
    pattern_sel = 2'd0; enable = 1'b1;
    capture(0, 21, 1'b0, 1'b0, got1);
    enable = 1'b0;
    capture(21, 43, 1'b1, 1'b0, got2);
    checks++;
    if (got1 + got2 !== 64) begin errors++; $display("FAIL drop_count: got %0d beats, want 64", got1 + got2); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if ({cap_data[i], cap_last[i]} !== {exp_bar(i % 16), (i % 16 == 15)}) begin
        errors++; $display("FAIL drop_beat%0d: got %h l%b, want %h l%b", i, cap_data[i], cap_last[i],
                           exp_bar(i % 16), (i % 16 == 15));
      end
    end
    checks++;
    if ({tvalid, busy, fdone, fcount} !== {3'b001, 16'd1}) begin
      errors++; $display("FAIL drop_idle: got v%b b%b fd%b fc%0d, want v0 b0 fd1 fc1", tvalid, busy, fdone, fcount);
    end
    vcnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tvalid || tuser) vcnt++;
    end
    checks++;
    if (vcnt !== 0 || fcount !== 16'd1) begin
      errors++; $display("FAIL drop_stays_idle: got %0d valid cycles fc=%0d, want 0 1", vcnt, fcount);
    end
  endtask

  task automatic test_pattern_latch();
    int g1, g2, g3;
    logic [23:0] want;
    do_reset();
    pattern_sel = 2'd3; solid_rgb = 24'h123456; enable = 1'b1;
    capture(0, 10, 1'b0, 1'b0, g1);
    pattern_sel = 2'd2; solid_rgb = 24'hABCDEF;
    capture(10, 54, 1'b0, 1'b0, g2);
    capture(64, 64, 1'b1, 1'b0, g3);
    checks++;
    if (g1 + g2 + g3 !== 128) begin errors++; $display("FAIL latch_count: got %0d beats, want 128", g1 + g2 + g3); end
    for (int i = 0; i < 128; i++) begin
      want = (i < 64) ? 24'h123456 : (((i % 16) < 8) ? 24'h000000 : 24'hFFFFFF);
      checks++;
      if (cap_data[i] !== want) begin errors++; $display("FAIL latch_beat%0d: got %h, want %h", i, cap_data[i], want); end
    end
    checks++;
    if (cap_user[64] !== 1'b1) begin errors++; $display("FAIL latch_tuser: got %b, want 1", cap_user[64]); end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    int got;
    do_reset();
    pattern_sel = 2'd0; enable = 1'b1;
    capture(0, 101, 1'b0, 1'b0, got);
    checks++;
    if ({tvalid, tdata, fcount} !== {1'b1, 24'h00FFFF, 16'd1} || got !== 101) begin
      errors++; $display("FAIL arst_before: got v%b %h fc%0d beats%0d, want v1 00ffff fc1 beats101", tvalid, tdata, fcount, got);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tvalid, tlast, tuser, fdone, busy, fcount, tdata} !== 45'd0) begin
      errors++; $display("FAIL arst_clear: got v%b l%b u%b fd%b b%b fc%0d %h, want all zero",
                         tvalid, tlast, tuser, fdone, busy, fcount, tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL arst_no_edge: got tvalid=%b, want 0", tvalid); end
    @(posedge clk); #1;
    checks++;
    if ({tvalid, tuser, tlast, busy, tdata} !== {4'b1101, 24'hFFFFFF}) begin
      errors++; $display("FAIL arst_restart: got v%b u%b l%b b%b %h, want v1 u1 l0 b1 ffffff",
                         tvalid, tuser, tlast, busy, tdata);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_colour_bars();
    test_backpressure();
    test_gaps();
    test_enable_drop();
    test_pattern_latch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_video_pattern_gen.md
Name: axis_video_pattern_gen

Overview:
AXI4-Stream video source. It produces complete RGB frames (24-bit, R[23:16] G[15:8] B[7:0]) with start-of-frame on tuser and end-of-line on tlast, and it honours tready backpressure. It is the transmit end of the video stream that the Sobel pipeline consumes. Its uses are standalone bring-up and the closed-loop testbench source feeding the filter's slave port.

Parameters:
IMAGE_WIDTH, 1920, active pixels per line (>=8)
IMAGE_HEIGHT, 1080, active lines per frame (>=2)
LINE_GAP, 0, idle cycles with tvalid=0 inserted after each line except the last of a frame
FRAME_GAP, 0, idle cycles with tvalid=0 inserted after the last line of a frame

Ports:
clk  in  1  single clock; all logic rising-edge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  run request; level-sensitive
pattern_sel  in  2  0=colour bars, 1=gray ramp, 2=8x8 checkerboard, 3=solid
solid_rgb  in  24  colour used for pattern 3
m_axis_tdata  out  24  pixel RGB
m_axis_tvalid  out  1  beat valid
m_axis_tlast  out  1  last pixel of line
m_axis_tuser  out  1  first pixel of frame
m_axis_tready  in  1  downstream ready
frame_done  out  1  one-cycle pulse after the final beat of a frame
busy  out  1  high whenever state is not IDLE
frame_count  out  16  completed frames; wraps 0xFFFF->0

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, state IDLE, x=y=0, latched pattern/colour cleared. Clearing takes effect without a clock edge, including mid-frame. After release, the next frame restarts at x=0, y=0.
- All outputs are registered. No combinational path from tready to any output.
- FSM states: IDLE, ACTIVE, LGAP, FGAP.
- IDLE:
  - If enable=1 at a clock edge, go to ACTIVE.
  - tvalid=1 with pixel (0,0) and tuser=1 in the next cycle (1-cycle start latency).
  - pattern_sel and solid_rgb are latched at that edge.
- Handshake: a beat transfers on a rising edge where tvalid&&tready.
  - While tvalid=1 and tready=0, tdata/tlast/tuser hold stable and tvalid stays 1.
  - tvalid never drops without a transfer.
- ACTIVE:
  - x advances on each transfer.
  - tuser=1 iff x==0 && y==0.
  - tlast=1 iff x==IMAGE_WIDTH-1.
  - Transfers of consecutive beats are back-to-back when tready=1.
- End of line (transfer with tlast, y<IMAGE_HEIGHT-1): x=0, y++.
  - LINE_GAP>0: go to LGAP. tvalid=0 for exactly LINE_GAP cycles, then ACTIVE.
  - LINE_GAP=0: the next pixel is presented in the following cycle.
- End of frame (transfer with tlast, y==IMAGE_HEIGHT-1):
  - x=y=0, frame_count++, frame_done=1 for exactly the next cycle.
  - FRAME_GAP>0: go to FGAP for FRAME_GAP cycles with tvalid=0.
  - Then, or immediately when FRAME_GAP=0: enable=1 goes to ACTIVE with a fresh latch of pattern/colour; else IDLE.
- enable=0 mid-frame: the current frame completes in full, then IDLE. Frames are never truncated.
- pattern_sel/solid_rgb changes mid-frame: ignored until the next frame latch.
- Patterns use the latched selection and current (x,y):
  - 0, colour bars:
    - BAR_W = IMAGE_WIDTH/8 (integer division).
    - Bar index increments every BAR_W pixels and saturates at 7; the last bar absorbs the remainder.
    - Bar colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
    - The bar index is produced by a counter; no divider or multiplier in the datapath.
  - 1, gray ramp: {x[7:0], x[7:0], x[7:0]}.
  - 2, checkerboard: (x[3]^y[3]) ? FFFFFF : 000000.
  - 3, solid: latched solid_rgb.
- Counters: x is $clog2(IMAGE_WIDTH) bits, y is $clog2(IMAGE_HEIGHT) bits; both wrap only at frame/line end as above.

Test Plan:
1. W=16, H=4, gaps 0, pattern 0, enable=1, tready=1.
   - Required: 64 contiguous beats; tuser only on beat 0; tlast on beats 15, 31, 47, 63.
   - Beats 0-1=FFFFFF, 2=FFFF00, 14-15=000000.
   - frame_done pulses once; frame_count=1; second frame follows immediately with tuser.
2. Same configuration with pseudo-random tready (~50%).
   - Required: beat sequence identical to scenario 1.
   - tdata/tlast/tuser unchanged on every tvalid&&!tready cycle; no tvalid drop without a transfer.
3. LINE_GAP=3, FRAME_GAP=5.
   - Required: exactly 3 tvalid=0 cycles after beats 15, 31, 47.
   - Exactly 5 tvalid=0 cycles after beat 63; then tuser beat of the next frame.
4. enable dropped after beat 20.
   - Required: the frame still delivers all 64 beats; then tvalid=0, busy=0, frame_count=1, no further tuser.
5. Pattern change mid-frame: pattern_sel=3, solid_rgb=123456, switched to 2 at beat 10.
   - Required: all 64 beats of frame 1 are 123456.
   - Frame 2 is checkerboard: x 0-7 = 000000, x 8-15 = FFFFFF on every line.
6. rst_n pulsed low mid-line (beat 37) between clock edges.
   - Required: tvalid/tlast/tuser/frame_done/busy=0 and frame_count=0 immediately.
   - After release with enable=1: tvalid after one edge, first beat has tuser=1 with pixel (0,0).
